// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for hazard_ctrl: stage inputs into the controller and
// the hold/flush/redirect controls back out to the pipeline.
interface hazard_ctrl_if #(parameter int PC_W = 32);
  logic [4:0]      id_rs1_addr_i;
  logic            id_rs1_rd_i;
  logic [4:0]      id_rs2_addr_i;
  logic            id_rs2_rd_i;
  logic            ex_load_i;
  logic [4:0]      ex_rd_addr_i;
  logic            ex_jump_i;
  logic [PC_W-1:0] ex_jump_addr_i;
  logic            mem_req_i;
  logic            mem_ready_i;
  logic            hold_pc_o;
  logic            hold_if_id_o;
  logic            hold_id_ex_o;
  logic            hold_ex_mem_o;
  logic            flush_if_id_o;
  logic            flush_id_ex_o;
  logic            jump_o;
  logic [PC_W-1:0] jump_addr_o;
  logic [1:0]      state_o;
  logic [31:0]     stall_cnt_o;

  modport master (
    output id_rs1_addr_i, id_rs1_rd_i, id_rs2_addr_i, id_rs2_rd_i,
           ex_load_i, ex_rd_addr_i, ex_jump_i, ex_jump_addr_i,
           mem_req_i, mem_ready_i,
    input  hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o,
           flush_if_id_o, flush_id_ex_o, jump_o, jump_addr_o,
           state_o, stall_cnt_o
  );

  modport slave (
    input  id_rs1_addr_i, id_rs1_rd_i, id_rs2_addr_i, id_rs2_rd_i,
           ex_load_i, ex_rd_addr_i, ex_jump_i, ex_jump_addr_i,
           mem_req_i, mem_ready_i,
    output hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o,
           flush_if_id_o, flush_id_ex_o, jump_o, jump_addr_o,
           state_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-bus wait > taken jump > load-use stall.
// Define HAZARD_PERF_CNT_EN to build the saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int LU_CYCLES = 1,
  parameter int PC_W      = 32
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN = 2'd0, LU = 2'd1, MEMW = 2'd2} state_t;

  localparam logic [2:0] LU_INIT = 3'(LU_CYCLES - 1);

  state_t     state;
  logic [2:0] lu_cnt;
  logic       mem_wait;
  logic       load_use;
  logic       lu_stall;

  assign mem_wait = hz.mem_req_i & ~hz.mem_ready_i;
  assign load_use = hz.ex_load_i && (hz.ex_rd_addr_i != 5'd0) &&
                    ((hz.id_rs1_rd_i && (hz.id_rs1_addr_i == hz.ex_rd_addr_i)) ||
                     (hz.id_rs2_rd_i && (hz.id_rs2_addr_i == hz.ex_rd_addr_i)));
  assign lu_stall = load_use || (state == LU);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      lu_cnt <= 3'd0;
    end else if (mem_wait) begin
      state  <= MEMW;
      lu_cnt <= 3'd0;
    end else if (hz.ex_jump_i) begin
      state  <= RUN;
      lu_cnt <= 3'd0;
    end else if (state == LU) begin
      // LU ignores a fresh load_use; RUN re-examines it after the sequence.
      if (lu_cnt == 3'd1) begin
        state  <= RUN;
        lu_cnt <= 3'd0;
      end else begin
        lu_cnt <= lu_cnt - 3'd1;
      end
    end else if (load_use && (LU_CYCLES > 1)) begin
      state  <= LU;
      lu_cnt <= LU_INIT;
    end else begin
      state  <= RUN;
      lu_cnt <= 3'd0;
    end
  end

  // Outputs are combinational; gating with rst_n silences them during reset.
  always_comb begin
    hz.hold_pc_o     = 1'b0;
    hz.hold_if_id_o  = 1'b0;
    hz.hold_id_ex_o  = 1'b0;
    hz.hold_ex_mem_o = 1'b0;
    hz.flush_if_id_o = 1'b0;
    hz.flush_id_ex_o = 1'b0;
    hz.jump_o        = 1'b0;
    hz.jump_addr_o   = '0;
    if (rst_n) begin
      if (mem_wait) begin
        hz.hold_pc_o     = 1'b1;
        hz.hold_if_id_o  = 1'b1;
        hz.hold_id_ex_o  = 1'b1;
        hz.hold_ex_mem_o = 1'b1;
      end else if (hz.ex_jump_i) begin
        hz.jump_o        = 1'b1;
        hz.jump_addr_o   = hz.ex_jump_addr_i;
        hz.flush_if_id_o = 1'b1;
        hz.flush_id_ex_o = 1'b1;
      end else if (lu_stall) begin
        hz.hold_pc_o     = 1'b1;
        hz.hold_if_id_o  = 1'b1;
        hz.flush_id_ex_o = 1'b1;
      end
    end
  end

  assign hz.state_o = state;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
    end else if (hz.hold_pc_o && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign hz.stall_cnt_o = stall_cnt;
`else
  assign hz.stall_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with LU_CYCLES=1, one with 3.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.PC_W(32)) if1 ();
  hazard_ctrl_if #(.PC_W(32)) if3 ();

  hazard_ctrl #(.LU_CYCLES(1), .PC_W(32)) dut1 (.clk(clk), .rst_n(rst_n), .hz(if1));
  hazard_ctrl #(.LU_CYCLES(3), .PC_W(32)) dut3 (.clk(clk), .rst_n(rst_n), .hz(if3));

  // {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, flush_if_id, flush_id_ex, jump}
  logic [6:0] ctl1, ctl3;
  assign ctl1 = {if1.hold_pc_o, if1.hold_if_id_o, if1.hold_id_ex_o, if1.hold_ex_mem_o,
                 if1.flush_if_id_o, if1.flush_id_ex_o, if1.jump_o};
  assign ctl3 = {if3.hold_pc_o, if3.hold_if_id_o, if3.hold_id_ex_o, if3.hold_ex_mem_o,
                 if3.flush_if_id_o, if3.flush_id_ex_o, if3.jump_o};

  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_LU    = 7'b1100010;
  localparam logic [6:0] C_JUMP  = 7'b0000111;
  localparam logic [6:0] C_MEMW  = 7'b1111000;

  typedef struct {
    logic [4:0]  rs1;
    logic        rs1_rd;
    logic [4:0]  rs2;
    logic        rs2_rd;
    logic        load;
    logic [4:0]  rd;
    logic        jump;
    logic [31:0] jaddr;
    logic        mreq;
    logic        mrdy;
    logic [6:0]  exp_ctl;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic rs1_rd, input logic [4:0] rs2,
                       input logic rs2_rd, input logic load, input logic [4:0] rd,
                       input logic jump, input logic [31:0] jaddr,
                       input logic mreq, input logic mrdy);
    if1.id_rs1_addr_i = rs1;  if3.id_rs1_addr_i = rs1;
    if1.id_rs1_rd_i   = rs1_rd; if3.id_rs1_rd_i = rs1_rd;
    if1.id_rs2_addr_i = rs2;  if3.id_rs2_addr_i = rs2;
    if1.id_rs2_rd_i   = rs2_rd; if3.id_rs2_rd_i = rs2_rd;
    if1.ex_load_i     = load; if3.ex_load_i     = load;
    if1.ex_rd_addr_i  = rd;   if3.ex_rd_addr_i  = rd;
    if1.ex_jump_i     = jump; if3.ex_jump_i     = jump;
    if1.ex_jump_addr_i = jaddr; if3.ex_jump_addr_i = jaddr;
    if1.mem_req_i     = mreq; if3.mem_req_i     = mreq;
    if1.mem_ready_i   = mrdy; if3.mem_ready_i   = mrdy;
  endtask

  task automatic idle();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic load_use5();
    drive(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    vecs[0]  = '{5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, C_NONE, 32'h0};
    vecs[1]  = '{5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0, C_LU,   32'h0};
    vecs[2]  = '{5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0, C_LU,   32'h0};
    vecs[3]  = '{5'd5, 1'b0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0, C_NONE, 32'h0};
    vecs[4]  = '{5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, C_NONE, 32'h0};
    vecs[5]  = '{5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 32'h0, 1'b0, 1'b0, C_NONE, 32'h0};
    vecs[6]  = '{5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 5'd7, 1'b0, 32'h0, 1'b0, 1'b0, C_NONE, 32'h0};
    vecs[7]  = '{5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 32'h100, 1'b0, 1'b0, C_JUMP, 32'h100};
    vecs[8]  = '{5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, C_JUMP, 32'hDEADBEEF};
    vecs[9]  = '{5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0, C_MEMW, 32'h0};
    vecs[10] = '{5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 32'h100, 1'b1, 1'b0, C_MEMW, 32'h0};
    vecs[11] = '{5'd9, 1'b0, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 32'h0, 1'b1, 1'b1, C_LU,   32'h0};
    vecs[12] = '{5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h44, 1'b1, 1'b1, C_JUMP, 32'h44};
    vecs[13] = '{5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h55, 1'b0, 1'b1, C_NONE, 32'h0};

    // Reset state with aggressive inputs present
    drive(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 32'h100, 1'b1, 1'b0);
    #12;
    check("reset_ctl1", 32'(ctl1), 32'(C_NONE));
    check("reset_ctl3", 32'(ctl3), 32'(C_NONE));
    check("reset_addr1", if1.jump_addr_o, 32'h0);
    check("reset_state1", 32'(if1.state_o), 32'd0);
    check("reset_cnt1", if1.stall_cnt_o, 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // Single-cycle vectors on the LU_CYCLES=1 instance (RUN rules apply in RUN or released MEMW)
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rs1, vecs[i].rs1_rd, vecs[i].rs2, vecs[i].rs2_rd, vecs[i].load,
            vecs[i].rd, vecs[i].jump, vecs[i].jaddr, vecs[i].mreq, vecs[i].mrdy);
      @(negedge clk);
      check($sformatf("vec%0d_ctl", i), 32'(ctl1), 32'(vecs[i].exp_ctl));
      check($sformatf("vec%0d_addr", i), if1.jump_addr_o, vecs[i].exp_addr);
      next_cycle();
    end

    // LU_CYCLES=1: one stall cycle then clear
    do_reset();
    load_use5();
    @(negedge clk);
    check("lu1_stall", 32'(ctl1), 32'(C_LU));
    next_cycle();
    idle();
    @(negedge clk);
    check("lu1_release", 32'(ctl1), 32'(C_NONE));
    check("lu1_state", 32'(if1.state_o), 32'd0);
    next_cycle();

    // Data-bus wait for three cycles, released the cycle ready rises
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0);
      @(negedge clk);
      check($sformatf("memw%0d_ctl", i), 32'(ctl1), 32'(C_MEMW));
      check($sformatf("memw%0d_state", i), 32'(if1.state_o), (i == 0) ? 32'd0 : 32'd2);
      next_cycle();
    end
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b1, 1'b1);
    @(negedge clk);
    check("memw_ready_ctl", 32'(ctl1), 32'(C_NONE));
    check("memw_ready_state", 32'(if1.state_o), 32'd2);
    next_cycle();
    idle();
    @(negedge clk);
    check("memw_after_state", 32'(if1.state_o), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt", if1.stall_cnt_o, 32'd3);
`else
    check("stall_cnt", if1.stall_cnt_o, 32'd0);
`endif
    next_cycle();

    // LU_CYCLES=3: three stall cycles, LU ignores load_use after entry
    do_reset();
    load_use5();
    @(negedge clk);
    check("lu3_c0_ctl", 32'(ctl3), 32'(C_LU));
    check("lu3_c0_state", 32'(if3.state_o), 32'd0);
    next_cycle();
    idle();
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("lu3_c%0d_ctl", i), 32'(ctl3), 32'(C_LU));
      check($sformatf("lu3_c%0d_state", i), 32'(if3.state_o), 32'd1);
      next_cycle();
    end
    @(negedge clk);
    check("lu3_done_ctl", 32'(ctl3), 32'(C_NONE));
    check("lu3_done_state", 32'(if3.state_o), 32'd0);
    next_cycle();

    // Jump preempts an LU sequence
    load_use5();
    next_cycle();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h200, 1'b0, 1'b0);
    @(negedge clk);
    check("lu3_jump_ctl", 32'(ctl3), 32'(C_JUMP));
    check("lu3_jump_addr", if3.jump_addr_o, 32'h200);
    next_cycle();
    idle();
    @(negedge clk);
    check("lu3_jump_after_ctl", 32'(ctl3), 32'(C_NONE));
    check("lu3_jump_after_state", 32'(if3.state_o), 32'd0);
    next_cycle();

    // Reset during the second stall cycle abandons the sequence
    load_use5();
    next_cycle();
    idle();
    @(negedge clk);
    check("lu3_rst_pre_state", 32'(if3.state_o), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("lu3_rst_ctl", 32'(ctl3), 32'(C_NONE));
    check("lu3_rst_state", 32'(if3.state_o), 32'd0);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check("lu3_post_rst_ctl", 32'(ctl3), 32'(C_NONE));
    check("lu3_post_rst_state", 32'(if3.state_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter LU_CYCLES, default 1, bubble cycles per load-use hazard (legal 1..7).
REQ-002 SHALL have parameter PC_W, default 32, jump target width.
REQ-003 SHALL have the following ports:
  clk             in   1     single clock, rising edge
  rst_n           in   1     asynchronous active-low reset
  id_rs1_addr_i   in   5     ID-stage source register 1
  id_rs1_rd_i     in   1     ID reads rs1
  id_rs2_addr_i   in   5     ID-stage source register 2
  id_rs2_rd_i     in   1     ID reads rs2
  ex_load_i       in   1     EX holds a load
  ex_rd_addr_i    in   5     EX destination register
  ex_jump_i       in   1     EX resolved a taken jump/branch
  ex_jump_addr_i  in   PC_W  jump target
  mem_req_i       in   1     MEM-stage data-bus request
  mem_ready_i     in   1     data-bus response valid
  hold_pc_o       out  1     freeze PC
  hold_if_id_o    out  1     freeze IF/ID register
  hold_id_ex_o    out  1     freeze ID/EX register
  hold_ex_mem_o   out  1     freeze EX/MEM register
  flush_if_id_o   out  1     load NOP into IF/ID
  flush_id_ex_o   out  1     load NOP into ID/EX
  jump_o          out  1     redirect PC this cycle
  jump_addr_o     out  PC_W  redirect target
  state_o         out  2     FSM state (RUN=0, LU=1, MEMW=2)
  stall_cnt_o     out  32    stall-cycle count (macro only, see REQ-021)

Function
REQ-004 SHALL implement FSM states RUN, LU, MEMW; all outputs combinational from state and inputs.
REQ-005 SHALL define mem_wait = mem_req_i & ~mem_ready_i.
REQ-006 SHALL define load_use = ex_load_i & ex_rd_addr_i!=0 & ((id_rs1_rd_i & rs1==rd) | (id_rs2_rd_i & rs2==rd)); x0 never hazards.
REQ-007 Priority per cycle SHALL be mem_wait > ex_jump_i > load_use.
REQ-008 mem_wait (any state) SHALL assert all four hold_* outputs, no flush, jump_o=0; next state MEMW.
REQ-009 MEMW SHALL persist while mem_wait; on mem_ready_i=1 the same cycle SHALL be evaluated with RUN rules (zero-cycle release).
REQ-010 ex_jump_i without mem_wait SHALL assert jump_o, jump_addr_o=ex_jump_addr_i, flush_if_id_o, flush_id_ex_o, no holds; next state RUN, LU counter cleared.
REQ-011 load_use without mem_wait/jump SHALL assert hold_pc_o, hold_if_id_o, flush_id_ex_o; if LU_CYCLES>1 enter LU with counter = LU_CYCLES-1.
REQ-012 LU SHALL repeat REQ-011 outputs regardless of load_use, decrement counter, return to RUN at counter 1->0; jump or mem_wait preempt per REQ-007.
REQ-013 jump_addr_o SHALL be 0 when jump_o=0.
REQ-014 hold and flush SHALL never both assert for the same pipeline register.
REQ-015 No hazard in RUN SHALL leave all outputs 0.

Reset
REQ-016 rst_n low SHALL asynchronously force state RUN, LU counter 0, stall_cnt_o 0.
REQ-017 During reset all hold_*, flush_*, jump_o SHALL be 0 and jump_addr_o 0.
REQ-018 Reset mid-LU or mid-MEMW SHALL abandon the sequence; first post-reset cycle evaluated as RUN.

Configuration
REQ-019 Macro HAZARD_PERF_CNT_EN SHALL gate the stall counter.
REQ-020 Defined: stall_cnt_o SHALL increment by 1 each cycle hold_pc_o=1, saturating at 0xFFFF_FFFF.
REQ-021 Undefined: stall_cnt_o SHALL be tied to 0 and no counter register inferred.

Verification
REQ-022 Load x5 in EX, ID reads rs1=x5, LU_CYCLES=1 -> one cycle hold_pc/hold_if_id/flush_id_ex=1, then all 0.
REQ-023 Load to x0, ID reads x0 -> no hold, no flush.
REQ-024 mem_req_i=1, mem_ready_i=0 for 3 cycles then 1 -> holds asserted 3 cycles, state_o=2, released same cycle ready rises.
REQ-025 ex_jump_i=1, target 0x0000_0100, simultaneous load_use -> jump_o=1, jump_addr_o=0x100, both flushes=1, no holds.
REQ-026 LU_CYCLES=3, load-use, rst_n low in 2nd stall cycle -> outputs 0 immediately, state_o=0.
REQ-027 HAZARD_PERF_CNT_EN defined, scenario REQ-024 -> stall_cnt_o=3; undefined -> stall_cnt_o=0.
